// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB master bridge and its companion memory slave.
//   apb_state_e : APB transfer phase, encoded identically on both sides.
//   APB_ADDR_W  : default address width.
//   APB_DATA_W  : default data width.
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;

endpackage : apb_pkg

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// Single-outstanding APB requester. Accepts one read/write command on a
// valid/ready port, runs it through APB SETUP and ACCESS, waits on PREADY
// (optionally bounded by TIMEOUT ACCESS cycles) and returns the result on a
// one-entry response port held until consumed.
//
// Ports:
//   PCLK, PRESET          : clock (rising edge), async active-low reset
//   req_valid/req_ready   : command handshake
//   req_write/addr/wdata  : command fields (wdata ignored on reads)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata, rsp_err    : read data (0 on writes/timeouts), timeout flag
//   PSEL, PENABLE, PADDR,
//   PWRITE, PWDATA        : registered APB master outputs
//   PRDATA, PREADY        : APB slave returns
// -----------------------------------------------------------------------------
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              accept;

  // Held low during reset; otherwise only IDLE with an empty response slot
  // may take a command, so a response clear and a new accept never coincide.
  assign req_ready = PRESET && (state_q == IDLE) && !rsp_valid_q;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          paddr_d   = req_addr;
          pwrite_d  = req_write;
          pwdata_d  = req_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ACCESS;
      end

      ACCESS: begin
        // PREADY wins over a timeout firing in the same cycle.
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule : apb_master_bridge

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
// Drives apb_master_bridge (TIMEOUT=4) against a behavioural APB memory slave
// with a programmable number of wait states. Expected responses come from a
// transaction-level model: a reference memory plus the rule "a transfer with
// N wait states times out iff N >= TIMEOUT".
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  // ---------------- behavioural APB memory slave ----------------
  logic [DW-1:0] slv_mem [0:255];
  int            acc_cnt = 0;
  int            wait_target = 0;
  bit            mem_clear = 1'b0;

  assign PREADY = PSEL && PENABLE && (acc_cnt >= wait_target);
  assign PRDATA = slv_mem[PADDR];

  always @(posedge PCLK) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) slv_mem[i] <= 8'(i) ^ 8'h5A;
    end else if (PSEL && PENABLE && PREADY && PWRITE) begin
      slv_mem[PADDR] <= PWDATA;
    end
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [0:255];

  task automatic model_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input int waits, output int acc, output logic e,
                            output logic [7:0] rd);
    e   = (waits >= TO);
    acc = e ? TO : waits + 1;
    rd  = (w || e) ? 8'h00 : ref_mem[a];
    if (w && !e) ref_mem[a] = d;
  endtask

  // ---------------- driver / observer ----------------
  typedef struct {
    bit          done;
    bit          setup_ok;
    bit          stable;
    bit          idle_at_rsp;
    bit          rsp_seen;
    bit          rdy_at_rsp;
    bit          held_ok;
    bit          cleared;
    bit          rdy_after;
    logic [7:0]  paddr;
    logic [7:0]  pwdata;
    logic        pwrite;
    int          access_cycles;
    int          rsp_lat;
    logic [7:0]  rdata;
    logic        err;
  } obs_t;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Runs one transfer and records what the bus and response port did.
  // rsp_lat is counted in cycles after the accepting edge.
  task automatic run_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input int waits, input int hold, input bit keep_req,
                          input logic nw, input logic [7:0] na, input logic [7:0] nd,
                          output obs_t o);
    int cyc;
    o = '{default: 0};
    wait_target = waits;
    rsp_ready   = (hold == 0);
    req_write   = w;
    req_addr    = a;
    req_wdata   = d;
    req_valid   = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) step();
    if (!req_ready) begin
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      return;
    end
    step();
    req_valid  = 1'b0;
    o.setup_ok = PSEL && !PENABLE && !rsp_valid;
    o.paddr    = PADDR;
    o.pwdata   = PWDATA;
    o.pwrite   = PWRITE;
    o.stable   = 1'b1;
    cyc = 1;
    while (cyc < 60) begin
      step();
      cyc++;
      if (!PSEL) break;
      if (PENABLE) o.access_cycles++;
      else         o.setup_ok = 1'b0;
      if (PADDR !== o.paddr || PWDATA !== o.pwdata || PWRITE !== o.pwrite) o.stable = 1'b0;
    end
    if (PSEL) begin
      rsp_ready = 1'b1;
      return;
    end
    o.rsp_lat     = cyc;
    o.idle_at_rsp = !PENABLE;
    o.rsp_seen    = rsp_valid;
    o.rdy_at_rsp  = req_ready;
    o.rdata       = rsp_rdata;
    o.err         = rsp_err;
    o.held_ok     = 1'b1;
    if (keep_req) begin
      req_write = nw;
      req_addr  = na;
      req_wdata = nd;
      req_valid = 1'b1;
    end
    for (int k = 0; k < hold; k++) begin
      step();
      if (!rsp_valid || rsp_rdata !== o.rdata || rsp_err !== o.err || req_ready || PSEL)
        o.held_ok = 1'b0;
    end
    rsp_ready = 1'b1;
    step();
    o.cleared   = !rsp_valid;
    o.rdy_after = req_ready;
    o.done      = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    PRESET    = 1'b0;
    mem_clear = 1'b1;
    step();
    step();
    mem_clear = 1'b0;
    checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin errors++; $display("FAIL reset_apb_ctl got %b want 000", {PSEL, PENABLE, PWRITE}); end
    checks++; if ({PADDR, PWDATA} !== 16'h0000) begin errors++; $display("FAIL reset_apb_data got %h want 0000", {PADDR, PWDATA}); end
    checks++; if ({rsp_valid, rsp_err} !== 2'b00) begin errors++; $display("FAIL reset_rsp_flags got %b want 00", {rsp_valid, rsp_err}); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rsp_rdata got %h want 00", rsp_rdata); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    @(negedge PCLK);
    PRESET = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_write_basic();
    obs_t o; int acc; logic e; logic [7:0] rd;
    model_xfer(1'b1, 8'h05, 8'hA5, 0, acc, e, rd);
    run_xfer(1'b1, 8'h05, 8'hA5, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00, o);
    checks++; if (!o.done) begin errors++; $display("FAIL wr_done got 0 want 1"); end
    checks++; if (!o.setup_ok) begin errors++; $display("FAIL wr_setup got 0 want 1"); end
    checks++; if (o.access_cycles != acc) begin errors++; $display("FAIL wr_access got %0d want %0d", o.access_cycles, acc); end
    checks++; if ({o.paddr, o.pwdata, o.pwrite} !== {8'h05, 8'hA5, 1'b1}) begin errors++; $display("FAIL wr_bus got %h/%h/%b want 05/a5/1", o.paddr, o.pwdata, o.pwrite); end
    checks++; if (o.rsp_lat != 3) begin errors++; $display("FAIL wr_latency got %0d want 3", o.rsp_lat); end
    checks++; if ({o.rsp_seen, o.err, o.rdata} !== {1'b1, e, rd}) begin errors++; $display("FAIL wr_rsp got v%b e%b d%h want v1 e%b d%h", o.rsp_seen, o.err, o.rdata, e, rd); end
    checks++; if (o.rdy_at_rsp !== 1'b0) begin errors++; $display("FAIL wr_ready_at_rsp got 1 want 0"); end
    checks++; if ({o.cleared, o.rdy_after} !== 2'b11) begin errors++; $display("FAIL wr_t4 got %b want 11", {o.cleared, o.rdy_after}); end
  endtask

  task automatic test_readback();
    obs_t o1, o2; int acc; logic e; logic [7:0] rd;
    model_xfer(1'b1, 8'h1F, 8'h3C, 0, acc, e, rd);
    run_xfer(1'b1, 8'h1F, 8'h3C, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00, o1);
    model_xfer(1'b0, 8'h1F, 8'h00, 0, acc, e, rd);
    run_xfer(1'b0, 8'h1F, 8'h00, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00, o2);
    checks++; if (o1.idle_at_rsp !== 1'b1 || !o1.done) begin errors++; $display("FAIL rb_idle_gap got %b want 1", o1.idle_at_rsp); end
    checks++; if (o2.rdata !== rd || rd !== 8'h3C) begin errors++; $display("FAIL rb_rdata got %h want 3c (model %h)", o2.rdata, rd); end
    checks++; if ({o2.err, o2.pwrite, o2.paddr} !== {1'b0, 1'b0, 8'h1F}) begin errors++; $display("FAIL rb_bus got e%b w%b a%h want e0 w0 a1f", o2.err, o2.pwrite, o2.paddr); end
  endtask

  task automatic test_wait_states();
    obs_t o; int acc; logic e; logic [7:0] rd;
    // Three wait states: PREADY arrives exactly when the timeout would fire.
    model_xfer(1'b1, 8'h40, 8'h99, 3, acc, e, rd);
    run_xfer(1'b1, 8'h40, 8'h99, 3, 0, 1'b0, 1'b0, 8'h00, 8'h00, o);
    checks++; if (o.access_cycles != acc) begin errors++; $display("FAIL ws_access got %0d want %0d", o.access_cycles, acc); end
    checks++; if (!o.stable) begin errors++; $display("FAIL ws_stable got 0 want 1"); end
    checks++; if (o.err !== e) begin errors++; $display("FAIL ws_err got %b want %b", o.err, e); end
    checks++; if (o.rsp_lat != acc + 2) begin errors++; $display("FAIL ws_latency got %0d want %0d", o.rsp_lat, acc + 2); end
  endtask

  task automatic test_timeout();
    obs_t o; int acc; logic e; logic [7:0] rd;
    model_xfer(1'b1, 8'h22, 8'h77, 1000, acc, e, rd);
    run_xfer(1'b1, 8'h22, 8'h77, 1000, 0, 1'b0, 1'b0, 8'h00, 8'h00, o);
    checks++; if (o.access_cycles != TO) begin errors++; $display("FAIL to_access got %0d want %0d", o.access_cycles, TO); end
    checks++; if ({o.idle_at_rsp, o.rsp_seen, o.err} !== {1'b1, 1'b1, e}) begin errors++; $display("FAIL to_rsp got idle%b v%b e%b want idle1 v1 e%b", o.idle_at_rsp, o.rsp_seen, o.err, e); end
    checks++; if (o.rdata !== 8'h00) begin errors++; $display("FAIL to_rdata got %h want 00", o.rdata); end
    model_xfer(1'b0, 8'h22, 8'h00, 0, acc, e, rd);
    run_xfer(1'b0, 8'h22, 8'h00, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00, o);
    checks++; if ({o.err, o.rdata} !== {e, rd}) begin errors++; $display("FAIL to_mem_untouched got e%b %h want e%b %h", o.err, o.rdata, e, rd); end
  endtask

  task automatic test_backpressure();
    obs_t o; int acc; logic e; logic [7:0] rd; bit seen;
    model_xfer(1'b0, 8'h1F, 8'h00, 0, acc, e, rd);
    run_xfer(1'b0, 8'h1F, 8'h00, 0, 5, 1'b1, 1'b1, 8'h30, 8'hC3, o);
    checks++; if (o.rdata !== rd) begin errors++; $display("FAIL bp_rdata got %h want %h", o.rdata, rd); end
    checks++; if (!o.held_ok || o.rdy_at_rsp) begin errors++; $display("FAIL bp_hold got held%b rdy%b want held1 rdy0", o.held_ok, o.rdy_at_rsp); end
    checks++; if ({o.cleared, o.rdy_after, PSEL} !== 3'b110) begin errors++; $display("FAIL bp_release got %b want 110", {o.cleared, o.rdy_after, PSEL}); end
    step();
    req_valid = 1'b0;
    checks++; if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b101, 8'h30}) begin errors++; $display("FAIL bp_second_setup got %b%b%b %h want 101 30", PSEL, PENABLE, PWRITE, PADDR); end
    model_xfer(1'b1, 8'h30, 8'hC3, 0, acc, e, rd);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = rsp_valid;
    end
    checks++; if (!seen || {rsp_err, rsp_rdata} !== {e, rd}) begin errors++; $display("FAIL bp_second_rsp got v%b e%b %h want v1 e%b %h", seen, rsp_err, rsp_rdata, e, rd); end
    step();
  endtask

  task automatic test_async_reset();
    obs_t o; int acc; logic e; logic [7:0] rd; bit in_access;
    wait_target = 1000;
    req_write = 1'b0;
    req_addr  = 8'h10;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) step();
    step();
    req_valid = 1'b0;
    in_access = 1'b0;
    for (int i = 0; i < 5 && !in_access; i++) begin
      step();
      in_access = PENABLE;
    end
    checks++; if (!in_access) begin errors++; $display("FAIL ar_reach_access got 0 want 1"); end
    #3;
    PRESET = 1'b0;
    #1;
    checks++; if ({PSEL, PENABLE, rsp_valid, req_ready} !== 4'b0000) begin errors++; $display("FAIL ar_drop got %b want 0000", {PSEL, PENABLE, rsp_valid, req_ready}); end
    @(negedge PCLK);
    PRESET = 1'b1;
    wait_target = 0;
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got %b want 1", req_ready); end
    model_xfer(1'b0, 8'h1F, 8'h00, 0, acc, e, rd);
    run_xfer(1'b0, 8'h1F, 8'h00, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00, o);
    checks++; if (!o.done || o.access_cycles != acc || {o.err, o.rdata} !== {e, rd}) begin errors++; $display("FAIL ar_after got acc%0d e%b %h want acc%0d e%b %h", o.access_cycles, o.err, o.rdata, acc, e, rd); end
  endtask

  task automatic test_random();
    obs_t o; int acc; logic e; logic [7:0] rd;
    logic w; logic [7:0] a, d; int waits, hold;
    for (int n = 0; n < 40; n++) begin
      w     = 1'($urandom_range(0, 1));
      a     = 8'h80 + 8'($urandom_range(0, 7));
      d     = 8'($urandom);
      waits = int'($urandom_range(0, 6));
      hold  = int'($urandom_range(0, 2));
      model_xfer(w, a, d, waits, acc, e, rd);
      run_xfer(w, a, d, waits, hold, 1'b0, 1'b0, 8'h00, 8'h00, o);
      checks++; if (!o.done || !o.setup_ok || !o.stable) begin errors++; $display("FAIL rnd%0d_protocol got done%b setup%b stable%b want 111", n, o.done, o.setup_ok, o.stable); end
      checks++; if (o.access_cycles != acc || o.rsp_lat != acc + 2) begin errors++; $display("FAIL rnd%0d_timing got acc%0d lat%0d want acc%0d lat%0d", n, o.access_cycles, o.rsp_lat, acc, acc + 2); end
      checks++; if ({o.rsp_seen, o.err, o.rdata} !== {1'b1, e, rd}) begin errors++; $display("FAIL rnd%0d_rsp got v%b e%b %h want v1 e%b %h", n, o.rsp_seen, o.err, o.rdata, e, rd); end
      checks++; if (!o.held_ok || o.rdy_at_rsp || !o.cleared || !o.rdy_after || !o.idle_at_rsp) begin errors++; $display("FAIL rnd%0d_handshake got held%b rdy%b clr%b after%b idle%b want 10111", n, o.held_ok, o.rdy_at_rsp, o.cleared, o.rdy_after, o.idle_at_rsp); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    test_reset();
    test_write_basic();
    test_readback();
    test_wait_states();
    test_timeout();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

endmodule : tb_apb_master_bridge

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Upstream APB requester for the APB memory slave. It takes single read/write commands from a simple valid/ready request port. It drives the APB master signals (PSEL, PENABLE, PADDR, PWRITE, PWDATA) through the SETUP and ACCESS phases and waits on PREADY. It returns PRDATA, or a timeout error, on a one-entry response port. It is the only master on its APB segment.

Parameters:
ADDR_W, 8, width of req_addr and PADDR
DATA_W, 8, width of write/read data
TIMEOUT, 16, max ACCESS cycles without PREADY before abort; 0 = wait forever

Ports:
PCLK  in  1  APB clock, all logic rising-edge
PRESET  in  1  reset, asynchronous, active-low
req_valid  in  1  command present
req_ready  out  1  command accepted when req_valid && req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  transfer address
req_wdata  in  DATA_W  write data (ignored on reads)
rsp_valid  out  1  response held until rsp_ready
rsp_ready  in  1  response consumer ready
rsp_rdata  out  DATA_W  read data; 0 on writes and on timeout
rsp_err  out  1  1 = transfer aborted by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable (ACCESS phase)
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB slave ready

Behaviour:
- Reset (PRESET=0, async):
  - state=IDLE.
  - All outputs 0: PSEL, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_rdata, rsp_err.
  - wait_cnt=0.
  - Any in-flight transfer or pending response is dropped.
  - req_ready=0 while in reset.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE:
  - PSEL=0, PENABLE=0.
  - req_ready = !rsp_valid, so only one transfer is outstanding.
  - On accept: latch addr/write/wdata into PADDR/PWRITE/PWDATA; next state SETUP.
- SETUP (one cycle):
  - PSEL=1, PENABLE=0.
  - Next state is ACCESS unconditionally; wait_cnt=0.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR/PWRITE/PWDATA stable from SETUP through end of ACCESS.
  - PREADY=1 sampled:
    - Transfer completes; next state IDLE; PSEL and PENABLE are 0 on the following cycle.
    - rsp_valid=1 and rsp_err=0 on the following cycle.
    - rsp_rdata = PRDATA if read, else 0.
  - PREADY=0: wait_cnt increments (saturating).
  - If TIMEOUT!=0 and wait_cnt==TIMEOUT-1 with PREADY=0: abort; next state IDLE; rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - PREADY=1 in the same cycle the timeout would fire: treated as success.
- Idle gap: every completion is followed by at least one cycle with PSEL=0 and PENABLE=0. No back-to-back SETUP; the slave FSM requires passing through IDLE.
- Latency, PREADY high on first ACCESS cycle, accept at edge T:
  - SETUP in cycle T+1, ACCESS in T+2.
  - rsp_valid=1 in T+3.
  - With rsp_ready=1, rsp_valid clears at T+4; req_ready=1 in T+4.
- Response port:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - Clearing rsp_valid and accepting a new request never happen in the same cycle.
- Outside a transfer: PADDR/PWRITE/PWDATA keep their last value (no toggling).
- Widths:
  - wait_cnt is $clog2(TIMEOUT+1) bits; 1 bit minimum when TIMEOUT=0.
  - No address range checking; the full ADDR_W is passed through.

Decomposition:
- Package apb_pkg holds:
  - apb_state_e enum {IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10}, shared with the slave's encoding.
  - Default ADDR_W/DATA_W localparams.
- Single module; no sub-module needed. The wait counter is a few lines inline.

Test Plan:
- Write, PREADY tied 1: req addr=0x05 wdata=0xA5 -> PSEL 1 for 2 cycles, PENABLE 1 only in the second, PADDR=0x05, PWDATA=0xA5, PWRITE=1; rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
- Read-back through the slave: write 0x3C to 0x1F, then read 0x1F -> rsp_rdata=0x3C, rsp_err=0; at least one PSEL=0 cycle between the two transfers.
- Wait states: PREADY low for 3 ACCESS cycles, TIMEOUT=16 -> PENABLE high 4 cycles, PADDR/PWDATA stable throughout, rsp_err=0.
- Timeout: PREADY stuck 0, TIMEOUT=4 -> ACCESS exactly 4 cycles, then PSEL=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Backpressure: rsp_ready=0 for 5 cycles with req_valid held 1 -> req_ready stays 0 and response fields are stable; second transfer's SETUP starts only after the rsp handshake.
- Async reset mid-ACCESS: PRESET low between edges -> PSEL/PENABLE/rsp_valid drop to 0 immediately; after release, req_ready=1 and a new read completes normally.
